// File: rtl/vball_pkg.sv
// Shared definitions for the PCM ROM cache: address/word widths, FSM states
// and the byte-lane selector used on DDRAM words.
package vball_pkg;

    localparam int unsigned PCM_AW = 18;
    localparam int unsigned DDR_DW = 64;
    localparam int unsigned WORD_W = PCM_AW - 3;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StPref,
        StPend
    } pcm_state_e;

    function automatic logic [7:0] sel_byte(input logic [DDR_DW-1:0] w, input logic [2:0] s);
        return w[{s, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pcm_line_store.sv
// Direct-mapped line storage: tag plus one 64-bit DDRAM word per line.
// Single synchronous write port, combinational read port, no reset.
module pcm_line_store
    import vball_pkg::*;
#(
    parameter int unsigned LINES = 4,
    parameter int unsigned TAG_W = 13
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(LINES)-1:0] waddr,
    input  logic [TAG_W-1:0]         wtag,
    input  logic [DDR_DW-1:0]        wdata,
    input  logic [$clog2(LINES)-1:0] raddr,
    output logic [TAG_W-1:0]         rtag,
    output logic [DDR_DW-1:0]        rdata
);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DDR_DW-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[waddr]  <= wtag;
            data_mem[waddr] <= wdata;
        end
    end

    assign rtag  = tag_mem[raddr];
    assign rdata = data_mem[raddr];

endmodule

// File: rtl/pcm_rom_cache.sv
// Small direct-mapped read cache between the PCM player and DDRAM channel 1,
// with optional next-line prefetch after each demand fill.
module pcm_rom_cache
    import vball_pkg::*;
#(
    parameter int unsigned LINES    = 4,
    parameter int unsigned PREFETCH = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              pcm_rom_read,
    input  logic [PCM_AW-1:0] pcm_rom_addr,
    output logic [7:0]        pcm_rom_data,
    output logic              pcm_rom_data_rdy,
    output logic [PCM_AW-1:0] ch1_addr,
    output logic              ch1_req,
    input  logic              ch1_ready,
    input  logic [DDR_DW-1:0] ch1_dout
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = WORD_W - IW;

    pcm_state_e        state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic              req_q, req_d;
    logic [PCM_AW-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              rdy_q, rdy_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [2:0]        bsel_q, bsel_d;
    logic              pend_q, pend_d;
    logic [PCM_AW-1:0] pend_addr_q, pend_addr_d;
    logic              flushed_q, flushed_d;

    logic [PCM_AW-1:0] lk_addr;
    logic [WORD_W-1:0] lk_word, nx_word, w_word;
    logic [IW-1:0]     rd_idx;
    logic [TW-1:0]     rd_tag;
    logic [DDR_DW-1:0] rd_data;
    logic              fill_done, keep, lk_hit, nx_hit;

    // A strobe captured during a prefetch is replayed from pend_addr_q once idle.
    assign lk_addr   = pend_q ? pend_addr_q : pcm_rom_addr;
    assign lk_word   = lk_addr[PCM_AW-1:3];
    assign nx_word   = word_q + WORD_W'(1);
    assign w_word    = addr_q[PCM_AW-1:3];
    assign rd_idx    = (state_q == StFill) ? nx_word[IW-1:0] : lk_word[IW-1:0];
    assign fill_done = ch1_ready && req_q && (state_q != StIdle);
    assign keep      = !flush && !flushed_q;
    assign lk_hit    = !flush && valid_q[lk_word[IW-1:0]] && (rd_tag == lk_word[WORD_W-1:IW]);
    assign nx_hit    = !flush && valid_q[nx_word[IW-1:0]] && (rd_tag == nx_word[WORD_W-1:IW]);

    pcm_line_store #(
        .LINES (LINES),
        .TAG_W (TW)
    ) u_store (
        .clk   (clk),
        .we    (fill_done),
        .waddr (w_word[IW-1:0]),
        .wtag  (w_word[WORD_W-1:IW]),
        .wdata (ch1_dout),
        .raddr (rd_idx),
        .rtag  (rd_tag),
        .rdata (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        req_d       = req_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdy_d       = 1'b0;
        word_d      = word_q;
        bsel_d      = bsel_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        flushed_d   = flushed_q | flush;

        if (fill_done && keep) begin
            valid_d[w_word[IW-1:0]] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                flushed_d = 1'b0;
                if (pend_q || pcm_rom_read) begin
                    pend_d = 1'b0;
                    if (lk_hit) begin
                        data_d = sel_byte(rd_data, lk_addr[2:0]);
                        rdy_d  = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = {lk_word, 3'b000};
                        word_d  = lk_word;
                        bsel_d  = lk_addr[2:0];
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (ch1_ready && req_q) begin
                    req_d     = 1'b0;
                    data_d    = sel_byte(ch1_dout, bsel_q);
                    rdy_d     = 1'b1;
                    flushed_d = 1'b0;
                    if (PREFETCH != 0 && !nx_hit) begin
                        addr_d  = {nx_word, 3'b000};
                        state_d = StPref;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StPref, StPend: begin
                // Request drops for one cycle between the demand fill and the prefetch.
                if (!req_q) begin
                    req_d = 1'b1;
                end
                if (pcm_rom_read && state_q == StPref) begin
                    pend_d      = 1'b1;
                    pend_addr_d = pcm_rom_addr;
                    state_d     = StPend;
                end
                if (ch1_ready && req_q) begin
                    req_d     = 1'b0;
                    flushed_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            word_q      <= '0;
            bsel_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            word_q      <= word_d;
            bsel_q      <= bsel_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            flushed_q   <= flushed_d;
        end
    end

    assign pcm_rom_data     = data_q;
    assign pcm_rom_data_rdy = rdy_q;
    assign ch1_addr         = addr_q;
    assign ch1_req          = req_q;

endmodule

// File: doc/pcm_rom_cache.md
PCM_ROM_CACHE -- requirements
Module: pcm_rom_cache

Interface
REQ-001 Parameter LINES, default 4, number of direct-mapped 64-bit lines; power of two, 2..16.
REQ-002 Parameter PREFETCH, default 1, 1 = fetch next sequential line after each demand fill.
REQ-003 clk  in  1  clock, the DDRAM channel clock (clk_48); all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 flush  in  1  active-high invalidate of all lines, tied to ioctl_download.
REQ-006 pcm_rom_read  in  1  one-cycle read strobe from the PCM player.
REQ-007 pcm_rom_addr  in  18  byte address, sampled on pcm_rom_read.
REQ-008 pcm_rom_data  out  8  read byte, valid when pcm_rom_data_rdy=1, held until next strobe.
REQ-009 pcm_rom_data_rdy  out  1  one-cycle completion pulse.
REQ-010 ch1_addr  out  18  DDRAM byte address, bits [2:0] always 0.
REQ-011 ch1_req  out  1  fill request, held high until ch1_ready.
REQ-012 ch1_ready  in  1  one-cycle pulse; ch1_dout valid in that cycle.
REQ-013 ch1_dout  in  64  fetched word; byte n = bits [8n+7:8n].

Function
REQ-014 Address split: word = addr[17:3], index = addr[3+:log2(LINES)], tag = remaining upper bits, byte select = addr[2:0].
REQ-015 States: IDLE, FILL (demand miss outstanding), PREF (prefetch outstanding), PEND (strobe captured during PREF, waiting).
REQ-016 IDLE, strobe, hit: pcm_rom_data_rdy and selected byte in the next cycle (latency 1).
REQ-017 IDLE, strobe, miss: next cycle ch1_req=1, ch1_addr={word,3'b0}, enter FILL.
REQ-018 FILL + ch1_ready: write line, set valid and tag, output byte and data_rdy next cycle (latency 1 from ch1_ready); PREFETCH=1 and next line (word+1, modulo 2^15) invalid or mistagged -> PREF; else IDLE.
REQ-019 PREF: ch1_req=1 with ch1_addr=(word+1)<<3; on ch1_ready write line, no data_rdy, return to IDLE.
REQ-020 Strobe in PREF -> capture address, enter PEND; on prefetch ch1_ready the line is written and the captured address is looked up as in IDLE in the following cycle.
REQ-021 Strobe in FILL or PEND: ignored, no data_rdy for it; requester contract forbids it.
REQ-022 ch1_req deasserts the cycle after ch1_ready; at most one DDRAM request outstanding.
REQ-023 Word address 0x7FFF wraps: prefetch address 0x00000.
REQ-024 flush clears all valid bits in the next cycle; while flush=1 no line becomes valid and strobes are treated as misses.
REQ-025 flush during FILL: request completes, byte and data_rdy delivered, line not validated.
REQ-026 flush during PREF/PEND: prefetch completes, data discarded; PEND lookup then misses.
REQ-027 flush and ch1_ready same cycle: flush wins for validity; data delivery per REQ-025.

Reset
REQ-028 reset_n low: state IDLE, all valid bits 0, ch1_req=0, ch1_addr=0, pcm_rom_data=0, pcm_rom_data_rdy=0, pending capture cleared.
REQ-029 Reset mid-FILL/PREF abandons request; a later stray ch1_ready in IDLE is ignored.
REQ-030 Line data and tag arrays need no reset.

Structure
REQ-031 Shared package vball_pkg holds the state enumeration, PCM address width (18), and DDRAM word width (64).
REQ-032 One sub-module, pcm_line_store: LINES x (tag+64) storage, single write port, combinational read port, valid bits kept in the parent.

Verification
REQ-033 Cold read 0x00005, ch1_dout=0x8877665544332211 -> one ch1_req at 0x00000, data 0x66, data_rdy one cycle after ch1_ready, then prefetch at 0x00008.
REQ-034 After REQ-033 prefetch done, reads 0x00000 and 0x0000F -> both hit, latency 1, no ch1_req.
REQ-035 Read 0x3FFFA -> demand at 0x3FFF8, prefetch at 0x00000.
REQ-036 Strobe 0x00010 during outstanding prefetch of 0x00008 -> PEND, prefetch completes, then miss fill at 0x00010, single data_rdy.
REQ-037 flush pulse one cycle before ch1_ready of demand fill -> byte delivered; re-read same address misses and requests again.
REQ-038 reset_n low during FILL, then spurious ch1_ready -> no data_rdy, outputs at reset values, next read requests normally.
